// File: rtl/regfile_write_arb.sv
// Round-robin write-port arbiter: N_REQ requesters share one register-file
// write port, one registered write per cycle, with stall and async reset.
module regfile_write_arb #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic [2:0]               wr_src
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_scan;
    logic [PTR_W-1:0] w_gnt_idx;
    logic [PTR_W-1:0] w_ptr_next;
    logic [N_REQ-1:0] w_grant;
    logic             w_fire;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_grant   = '0;
        w_fire    = 1'b0;
        w_gnt_idx = '0;
        w_scan    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_scan = PTR_W'((int'(r_ptr) + k) % N_REQ);
            if (!w_fire && req_valid[w_scan]) begin
                w_fire    = 1'b1;
                w_gnt_idx = w_scan;
            end
        end
        // Stall and reset override any grant, so no handshake can complete.
        if (stall || reset) begin
            w_fire = 1'b0;
        end
        if (w_fire) begin
            w_grant[w_gnt_idx] = 1'b1;
        end
    end

    assign req_ready  = w_grant;
    assign w_ptr_next = (w_gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_src  <= '0;
        end else begin
            wr_en <= w_fire;
            if (w_fire) begin
                r_ptr   <= w_ptr_next;
                wr_addr <= req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
                wr_data <= req_data[w_gnt_idx*DATA_W +: DATA_W];
                wr_src  <= 3'(w_gnt_idx);
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arb.sv
// Directed bench for regfile_write_arb: round robin, single requester, wrap,
// stall, mid-operation reset and same-address back-to-back writes.
module tb_regfile_write_arb;

    localparam int N_REQ  = 4;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    stall;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic [2:0]              wr_src;

    int total = 0;
    int bad   = 0;

    regfile_write_arb #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_src(wr_src)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; req_valid = 4'b1111;
        req_addr = '0; req_data = '0;
        step(); step();
        total++;
        if (req_ready !== 4'b0000) begin
            bad++; $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        total++;
        if ({wr_en, wr_src, wr_addr, wr_data} !== 39'h0) begin
            bad++; $display("FAIL reset_outputs: got en=%b src=%0d addr=%0d data=%h want all 0",
                            wr_en, wr_src, wr_addr, wr_data);
        end
        req_valid = '0;
        reset = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [38:0] exp;
        logic [3:0]  exp_rdy;
        for (int i = 0; i < N_REQ; i++) set_req(i, 3'(i + 1), 32'hA000_0000 + 32'(i));
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            int g;
            g = i % N_REQ;
            #1;
            exp_rdy = 4'b0001 << g;
            total++;
            if (req_ready !== exp_rdy) begin
                bad++; $display("FAIL rr_ready[%0d]: got %b want %b", i, req_ready, exp_rdy);
            end
            step();
            exp = {1'b1, 3'(g), 3'(g + 1), 32'hA000_0000 + 32'(g)};
            total++;
            if ({wr_en, wr_src, wr_addr, wr_data} !== exp) begin
                bad++; $display("FAIL rr_write[%0d]: got %h want %h", i, {wr_en, wr_src, wr_addr, wr_data}, exp);
            end
        end
        req_valid = '0;
        step();
        total++;
        if (wr_en !== 1'b0) begin
            bad++; $display("FAIL rr_idle_en: got %b want 0", wr_en);
        end
    endtask

    // Pointer is 1 on entry.
    task automatic test_single();
        set_req(2, 3'd5, 32'hDEAD_BEEF);
        req_valid = 4'b0100;
        #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++; $display("FAIL single_ready: got %b want 0100", req_ready);
        end
        step();
        req_valid = '0;
        total++;
        if ({wr_en, wr_src, wr_addr, wr_data} !== {1'b1, 3'd2, 3'd5, 32'hDEAD_BEEF}) begin
            bad++; $display("FAIL single_write: got en=%b src=%0d addr=%0d data=%h want 1/2/5/deadbeef",
                            wr_en, wr_src, wr_addr, wr_data);
        end
        step();
        total++;
        if ({wr_en, wr_src, wr_addr, wr_data} !== {1'b0, 3'd2, 3'd5, 32'hDEAD_BEEF}) begin
            bad++; $display("FAIL single_hold: got en=%b src=%0d addr=%0d data=%h want 0/2/5/deadbeef",
                            wr_en, wr_src, wr_addr, wr_data);
        end
    endtask

    // Pointer is 3 on entry.
    task automatic test_wrap();
        logic [3:0] vld [4] = '{4'b1001, 4'b1001, 4'b1011, 4'b1011};
        logic [3:0] rdy [4] = '{4'b1000, 4'b0001, 4'b0010, 4'b1000};
        logic [2:0] src [4] = '{3'd3, 3'd0, 3'd1, 3'd3};
        for (int i = 0; i < 4; i++) begin
            req_valid = vld[i];
            #1;
            total++;
            if (req_ready !== rdy[i]) begin
                bad++; $display("FAIL wrap_ready[%0d]: got %b want %b", i, req_ready, rdy[i]);
            end
            step();
            total++;
            if ({wr_en, wr_src} !== {1'b1, src[i]}) begin
                bad++; $display("FAIL wrap_src[%0d]: got en=%b src=%0d want en=1 src=%0d", i, wr_en, wr_src, src[i]);
            end
        end
        req_valid = '0;
        step();
    endtask

    // Pointer is 0 on entry.
    task automatic test_stall();
        stall = 1'b1; req_valid = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (req_ready !== 4'b0000) begin
                bad++; $display("FAIL stall_ready[%0d]: got %b want 0000", i, req_ready);
            end
            step();
            total++;
            if (wr_en !== 1'b0) begin
                bad++; $display("FAIL stall_en[%0d]: got %b want 0", i, wr_en);
            end
        end
        stall = 1'b0;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL stall_resume_ready: got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        total++;
        if ({wr_en, wr_src} !== {1'b1, 3'd0}) begin
            bad++; $display("FAIL stall_resume_write: got en=%b src=%0d want en=1 src=0", wr_en, wr_src);
        end
        step();
    endtask

    // Pointer is 1 on entry; the aborted grant of 2 would otherwise move it to 3.
    task automatic test_reset_mid();
        set_req(2, 3'd6, 32'h1234_5678);
        set_req(1, 3'd4, 32'h0000_0011);
        set_req(3, 3'd2, 32'h0000_0033);
        req_valid = 4'b0100;
        step();
        reset = 1'b1;
        req_valid = 4'b1010;
        #1;
        total++;
        if ({wr_en, wr_src, wr_addr, wr_data} !== 39'h0 || req_ready !== 4'b0000) begin
            bad++; $display("FAIL midreset_async: got en=%b src=%0d addr=%0d data=%h rdy=%b want all 0",
                            wr_en, wr_src, wr_addr, wr_data, req_ready);
        end
        step();
        reset = 1'b0;
        #1;
        total++;
        if ({wr_en, wr_src, wr_addr, wr_data} !== 39'h0) begin
            bad++; $display("FAIL midreset_after: got en=%b src=%0d addr=%0d data=%h want all 0",
                            wr_en, wr_src, wr_addr, wr_data);
        end
        total++;
        if (req_ready !== 4'b0010) begin
            bad++; $display("FAIL midreset_ptr: got ready %b want 0010", req_ready);
        end
        step();
        req_valid = '0;
        total++;
        if ({wr_en, wr_src, wr_addr, wr_data} !== {1'b1, 3'd1, 3'd4, 32'h0000_0011}) begin
            bad++; $display("FAIL midreset_write: got en=%b src=%0d addr=%0d data=%h want 1/1/4/00000011",
                            wr_en, wr_src, wr_addr, wr_data);
        end
        step();
        total++;
        if (wr_en !== 1'b0) begin
            bad++; $display("FAIL midreset_idle: got %b want 0", wr_en);
        end
    endtask

    // Pointer is 2 on entry, so requester 0 wins first and requester 1 writes last.
    task automatic test_back_to_back();
        set_req(0, 3'd7, 32'h0000_AAAA);
        set_req(1, 3'd7, 32'h0000_BBBB);
        req_valid = 4'b0011;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL b2b_ready0: got %b want 0001", req_ready);
        end
        step();
        req_valid = 4'b0010;
        total++;
        if ({wr_en, wr_src, wr_addr, wr_data} !== {1'b1, 3'd0, 3'd7, 32'h0000_AAAA}) begin
            bad++; $display("FAIL b2b_first: got en=%b src=%0d addr=%0d data=%h want 1/0/7/0000aaaa",
                            wr_en, wr_src, wr_addr, wr_data);
        end
        total++;
        if (req_ready !== 4'b0010) begin
            bad++; $display("FAIL b2b_ready1: got %b want 0010", req_ready);
        end
        step();
        req_valid = '0;
        total++;
        if ({wr_en, wr_src, wr_addr, wr_data} !== {1'b1, 3'd1, 3'd7, 32'h0000_BBBB}) begin
            bad++; $display("FAIL b2b_second: got en=%b src=%0d addr=%0d data=%h want 1/1/7/0000bbbb",
                            wr_en, wr_src, wr_addr, wr_data);
        end
        step();
        total++;
        if ({wr_en, wr_addr, wr_data} !== {1'b0, 3'd7, 32'h0000_BBBB}) begin
            bad++; $display("FAIL b2b_last: got en=%b addr=%0d data=%h want 0/7/0000bbbb",
                            wr_en, wr_addr, wr_data);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_wrap();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
